// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and the
// MEM/WB bundle layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  // MEM/WB bundle: {reg_write, mem_to_reg, alu_result[31:0], mem_rdata[31:0], rd[4:0]}
  localparam int MEMWB_W        = 71;
  localparam int RD_LSB         = 0;
  localparam int RD_W           = 5;
  localparam int MEM_RDATA_LSB  = 5;
  localparam int ALU_RESULT_LSB = 37;
  localparam int WORD_W         = 32;
  localparam int MEM_TO_REG_BIT = 69;
  localparam int REG_WRITE_BIT  = 70;

  function automatic logic [MEMWB_W-1:0] pack_memwb(
    input logic              reg_write,
    input logic              mem_to_reg,
    input logic [WORD_W-1:0] alu_result,
    input logic [WORD_W-1:0] mem_rdata,
    input logic [RD_W-1:0]   rd
  );
    return {reg_write, mem_to_reg, alu_result, mem_rdata, rd};
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single skid entry: payload register written only on load, plus a valid flag
// that clear drops (clear wins over load).
module pipe_skid_buf #(
  parameter int                WIDTH    = 71,
  parameter logic [WIDTH-1:0]  RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= RST_DATA;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. Defining PIPE_STAGE_SKID_EN adds a skid
// entry so in_ready comes from a register instead of out_ready.
//
//   state | meaning
//   EMPTY | no entry held, out_valid=0
//   FULL  | main register holds one entry
//   SKID  | main and skid both hold entries, in_ready=0 (skid build only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                WIDTH    = MEMWB_W,
  parameter logic [WIDTH-1:0]  RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic             out_valid_q;
  logic             accept;
  logic             consume;

  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid;
  logic             skid_load;
  logic             skid_clear;
  logic [WIDTH-1:0] skid_q;

  assign in_ready   = !skid_valid;
  assign skid_load  = !flush && (state == FULL) && accept && !consume;
  assign skid_clear = flush || ((state == SKID) && consume);

  pipe_skid_buf #(
    .WIDTH    (WIDTH),
    .RST_DATA (RST_DATA)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_data),
    .q     (skid_q),
    .valid (skid_valid)
  );
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      main_q      <= RST_DATA;
    end else if (flush) begin
      // main_q keeps its last value; only the valid state is discarded
      state       <= EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q      <= in_data;
            out_valid_q <= 1'b1;
            state       <= FULL;
          end
        end
        FULL: begin
          if (consume) begin
            if (accept) begin
              main_q <= in_data;
            end else begin
              state       <= EMPTY;
              out_valid_q <= 1'b0;
            end
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (accept) begin
            state <= SKID;
          end
`endif
        end
        SKID: begin
`ifdef PIPE_STAGE_SKID_EN
          if (consume) begin
            main_q <= skid_q;
            state  <= FULL;
          end
`else
          state       <= EMPTY;
          out_valid_q <= 1'b0;
`endif
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; covers both builds via PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  localparam int W = 71;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       fl;
    logic [7:0] d;
    logic       ev;
    logic       eir;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [7:0] d,
                              logic ev, logic eir, logic [7:0] ed);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d;
    v.ev = ev; v.eir = eir; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [W-1:0] d);
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = d;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for random traffic
  logic [W-1:0] sb_q[$];
  logic [W-1:0] next_id;

  task automatic rnd_cycle(input logic iv, input logic ordy);
    logic acc, cons;
    logic [W-1:0] exp;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    flush     = 1'b0;
    in_data   = next_id;
    #1;
    chk("rnd_out_valid", W'(out_valid), W'(sb_q.size() > 0));
`ifdef PIPE_STAGE_SKID_EN
    chk("rnd_in_ready", W'(in_ready), W'(sb_q.size() < 2));
`else
    chk("rnd_in_ready", W'(in_ready), W'((sb_q.size() == 0) || ordy));
`endif
    acc  = in_valid && in_ready;
    cons = out_valid && out_ready;
    if (cons) begin
      exp = (sb_q.size() > 0) ? sb_q[0] : '1;
      chk("rnd_order", out_data, exp);
    end
    @(posedge clk);
    if (cons && sb_q.size() > 0) void'(sb_q.pop_front());
    if (acc) begin
      sb_q.push_back(next_id);
      next_id = next_id + 1;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    next_id = W'(1);

    tbl[0]  = mk(1, 1, 0, 8'h01, 1, 1, 8'h01);
    tbl[1]  = mk(1, 1, 0, 8'h02, 1, 1, 8'h02);
    tbl[2]  = mk(1, 1, 0, 8'h03, 1, 1, 8'h03);
    tbl[3]  = mk(1, 1, 0, 8'h04, 1, 1, 8'h04);
    tbl[4]  = mk(1, 1, 0, 8'h05, 1, 1, 8'h05);
    tbl[5]  = mk(1, 1, 0, 8'h06, 1, 1, 8'h06);
    tbl[6]  = mk(1, 1, 0, 8'h07, 1, 1, 8'h07);
    tbl[7]  = mk(1, 1, 0, 8'h08, 1, 1, 8'h08);
    tbl[8]  = mk(0, 1, 0, 8'h00, 0, 1, 8'h08);
    tbl[9]  = mk(0, 1, 0, 8'h00, 0, 1, 8'h08);
    tbl[10] = mk(1, 1, 0, 8'h21, 1, 1, 8'h21);
    tbl[11] = mk(1, 1, 1, 8'h22, 0, 1, 8'h21);
    tbl[12] = mk(0, 1, 0, 8'h00, 0, 1, 8'h21);
    tbl[13] = mk(1, 1, 0, 8'h33, 1, 1, 8'h33);
    tbl[14] = mk(0, 1, 0, 8'h00, 0, 1, 8'h33);

    #12;
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst = 1'b0;

    // Streaming, gaps and flush from the table; first accept is the first edge after reset
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, W'(tbl[i].d));
      chk($sformatf("vec%0d_out_valid", i), W'(out_valid), W'(tbl[i].ev));
      chk($sformatf("vec%0d_out_data", i), out_data, W'(tbl[i].ed));
      chk($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(tbl[i].eir));
    end

    // Asynchronous reset while FULL with 0x55
    drive(1, 0, 0, W'(8'h55));
    chk("pre_rst_data", out_data, W'(8'h55));
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", W'(out_valid), '0);
    chk("async_rst_out_data", out_data, '0);
    chk("async_rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, '0);
    chk("post_rst_idle", W'(out_valid), '0);

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure into the skid entry
    drive(1, 0, 0, W'(8'hA1));
    drive(1, 0, 0, W'(8'hB2));
    chk("skid_in_ready", W'(in_ready), '0);
    chk("skid_hold_a", out_data, W'(8'hA1));
    drive(1, 0, 0, W'(8'hEE));
    chk("skid_hold_a2", out_data, W'(8'hA1));
    chk("skid_hold_valid", W'(out_valid), W'(1));
    drive(0, 1, 0, '0);
    chk("skid_drain_b", out_data, W'(8'hB2));
    chk("skid_drain_valid", W'(out_valid), W'(1));
    drive(0, 1, 0, '0);
    chk("skid_drain_empty", W'(out_valid), '0);

    // Flush from SKID with a simultaneous input C
    drive(1, 0, 0, W'(8'hA1));
    drive(1, 0, 0, W'(8'hB2));
    drive(1, 0, 1, W'(8'hC3));
    chk("flush_out_valid", W'(out_valid), '0);
    chk("flush_in_ready", W'(in_ready), W'(1));
    drive(0, 1, 0, '0);
    chk("flush_no_c_valid", W'(out_valid), '0);
    chk("flush_no_c_data", out_data, W'(8'hA1));
`else
    // Combinational in_ready from out_ready
    drive(1, 0, 0, W'(8'hA1));
    chk("ns_out_data", out_data, W'(8'hA1));
    chk("ns_in_ready_low", W'(in_ready), '0);
    drive(1, 0, 0, W'(8'hB2));
    chk("ns_hold_a", out_data, W'(8'hA1));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("ns_in_ready_high", W'(in_ready), W'(1));
    drive(0, 1, 0, '0);
    chk("ns_empty", W'(out_valid), '0);

    // Flush while FULL with a simultaneous input C
    drive(1, 1, 0, W'(8'hA1));
    drive(1, 0, 1, W'(8'hC3));
    chk("flush_out_valid", W'(out_valid), '0);
    chk("flush_in_ready", W'(in_ready), W'(1));
    drive(0, 1, 0, '0);
    chk("flush_no_c_data", out_data, W'(8'hA1));
`endif

    // Random valid/ready traffic against an in-order scoreboard
    sb_q.delete();
    for (int n = 0; n < 10000; n++)
      rnd_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60);
    for (int n = 0; n < 4; n++)
      rnd_cycle(1'b0, 1'b1);
    chk("rnd_drained", W'(sb_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 71, payload bits per entry (1+1+32+32+5 MEM/WB bundle).
REQ-002 SHALL have parameter RST_DATA, default 0, value loaded into payload registers on reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream entry present.
REQ-010 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload, driven directly from the main register.

Function
REQ-012 Transfer SHALL occur on an edge where valid and ready are both 1 on the same side; no other condition moves data.
REQ-013 Latency SHALL be one cycle: an entry accepted at edge N is on out_data with out_valid=1 after edge N.
REQ-014 Entries SHALL leave in acceptance order, none dropped, none duplicated.
REQ-015 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold constant.
REQ-016 Payload registers SHALL be written only on accept (clock-enable style); out_valid=0 leaves out_data at its last value.
REQ-017 State SHALL be one of EMPTY (no entry), FULL (main only), SKID (main+skid; SKID only with macro).
REQ-018 EMPTY: accept -> FULL; else stay.
REQ-019 FULL: consume with accept -> FULL (new data); consume only -> EMPTY; accept without consume -> SKID (macro) ; neither -> FULL.
REQ-020 SKID: consume -> FULL with main loaded from skid, in_ready=0 that cycle so no accept; no consume -> SKID.
REQ-021 flush=1 SHALL force EMPTY at the next edge regardless of simultaneous accept or consume; an input accepted on that edge is discarded.
REQ-022 in_ready SHALL be 1 for the cycle following a flush edge.
REQ-023 Simultaneous consume and accept in FULL SHALL sustain one transfer per cycle with no bubble.

Reset
REQ-024 rst=1 SHALL asynchronously force EMPTY: out_valid=0, out_data=RST_DATA, skid contents=RST_DATA, in_ready=1.
REQ-025 Reset asserted mid-transfer SHALL discard all held entries; no output until a new accept after rst deasserts.
REQ-026 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN defined: two-entry skid buffer compiled in, in_ready driven from a register (= skid empty), no combinational path out_ready -> in_ready.
REQ-028 Macro PIPE_STAGE_SKID_EN undefined: single entry, SKID state absent, in_ready = !out_valid | out_ready (combinational), FULL with accept and no consume impossible.
REQ-029 Both builds SHALL give identical cycle-level out_valid/out_data traces for any stimulus in which out_ready=1 whenever out_valid=1.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state enum (EMPTY, FULL, SKID) and the MEM/WB bundle width constant (71) and field offsets.
REQ-031 Skid entry SHALL be one sub-module pipe_skid_buf (WIDTH-bit register with load/valid/clear); instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-032 Reset: rst=1 while FULL with data 0x55 -> out_valid=0, out_data=0 immediately, in_ready=1.
REQ-033 Streaming: in_valid=1 for 8 cycles with data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, one-cycle latency, no bubble.
REQ-034 Backpressure (skid build): send A,B with out_ready=0 -> state SKID, in_ready=0, out_data=A held; raise out_ready -> A then B, no loss.
REQ-035 Flush: state SKID holding A,B, flush=1 with in_valid=1 data C -> next cycle out_valid=0, in_ready=1; C never appears.
REQ-036 Non-skid build: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
REQ-037 Random valid/ready over 10000 cycles in both builds -> scoreboard shows exact in-order delivery, zero drops, zero duplicates.
